// File: rtl/debounce_pkg.sv
// Shared constants and width helper for the multi-channel debouncer.
// Clock-derived defaults assume the 100 MHz Basys3 system clock.
package debounce_pkg;

   localparam int unsigned CLK_HZ      = 100_000_000;
   localparam int unsigned DEBOUNCE_MS = 10;
   localparam int unsigned LONG_MS     = 1000;

   localparam int unsigned CYCLES_PER_MS   = CLK_HZ / 1000;
   localparam int unsigned DEBOUNCE_CYCLES = CYCLES_PER_MS * DEBOUNCE_MS;
   localparam int unsigned LONG_CYCLES_DEF = CYCLES_PER_MS * LONG_MS;

   // Bits needed to hold 0..max_val inclusive, never less than one.
   function automatic int unsigned cnt_width(input int unsigned max_val);
      longint unsigned span;
      span = longint'(max_val) + 64'd1;
      if (span <= 64'd2)
         return 1;
      return $clog2(span);
   endfunction

endpackage

// File: rtl/debounce_ch.sv
// One debounce channel: synchroniser, mismatch counter, level, edge pulses.
// Optional hold counter for long-press pulses when DEBOUNCE_LONG_PRESS_EN is defined.
module debounce_ch
   import debounce_pkg::*;
#(
   parameter int unsigned CNT_MAX     = DEBOUNCE_CYCLES,
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned LONG_CYCLES = LONG_CYCLES_DEF,
   parameter bit          INV         = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic raw_i,
   output logic level_o,
   output logic rise_o,
   output logic fall_o,
   output logic rise_nxt_o,
   output logic long_o
);

   localparam int unsigned   CW       = cnt_width(CNT_MAX);
   localparam logic [CW-1:0] CNT_LAST = CW'(CNT_MAX - 1);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   s;
   logic [CW-1:0]          cnt_q, cnt_d;
   logic                   level_q, level_d;
   logic                   rise_q, rise_d;
   logic                   fall_q, fall_d;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], raw_i};
      end
   end

   assign s = sync_q[SYNC_STAGES-1] ^ INV;

   // Any cycle of agreement restarts the count, which is what rejects bounce.
   always_comb begin
      cnt_d   = cnt_q;
      level_d = level_q;
      rise_d  = 1'b0;
      fall_d  = 1'b0;
      if (s == level_q) begin
         cnt_d = '0;
      end else if (cnt_q == CNT_LAST) begin
         level_d = s;
         cnt_d   = '0;
         rise_d  = s;
         fall_d  = ~s;
      end else begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q   <= '0;
         level_q <= 1'b0;
         rise_q  <= 1'b0;
         fall_q  <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         level_q <= level_d;
         rise_q  <= rise_d;
         fall_q  <= fall_d;
      end
   end

   assign level_o    = level_q;
   assign rise_o     = rise_q;
   assign fall_o     = fall_q;
   assign rise_nxt_o = rise_d;

`ifdef DEBOUNCE_LONG_PRESS_EN
   localparam int unsigned   HW       = cnt_width(LONG_CYCLES);
   localparam logic [HW-1:0] HOLD_MAX = HW'(LONG_CYCLES);

   logic [HW-1:0] hold_q, hold_d;
   logic          long_q, long_d;

   // Counting starts the edge after level goes high, so the pulse lands
   // LONG_CYCLES cycles after the rise pulse; saturation gives one pulse per press.
   always_comb begin
      hold_d = hold_q;
      if (!level_q || fall_d) begin
         hold_d = '0;
      end else if (hold_q != HOLD_MAX) begin
         hold_d = hold_q + HW'(1);
      end
      long_d = (hold_d == HOLD_MAX) && (hold_q != HOLD_MAX);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         hold_q <= '0;
         long_q <= 1'b0;
      end else begin
         hold_q <= hold_d;
         long_q <= long_d;
      end
   end

   assign long_o = long_q;
`else
   assign long_o = 1'b0;
`endif

endmodule

// File: rtl/debounce_multi.sv
// N-channel debouncer for button/switch banks; rise replaces the old tx_start strobe.
// Define DEBOUNCE_LONG_PRESS_EN to build the per-channel long-press detectors.
module debounce_multi
   import debounce_pkg::*;
#(
   parameter int unsigned       N_CH        = 4,
   parameter int unsigned       CNT_MAX     = DEBOUNCE_CYCLES,
   parameter int unsigned       SYNC_STAGES = 2,
   parameter logic [N_CH-1:0]   INV_MASK    = '0,
   parameter int unsigned       LONG_CYCLES = LONG_CYCLES_DEF
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [N_CH-1:0] raw_in,
   output logic [N_CH-1:0] level,
   output logic [N_CH-1:0] rise,
   output logic [N_CH-1:0] fall,
   output logic            any_rise,
   output logic [N_CH-1:0] long_press
);

   logic [N_CH-1:0] rise_nxt;
   logic            any_rise_q, any_rise_d;

   for (genvar i = 0; i < N_CH; i++) begin : g_ch
      debounce_ch #(
         .CNT_MAX     (CNT_MAX),
         .SYNC_STAGES (SYNC_STAGES),
         .LONG_CYCLES (LONG_CYCLES),
         .INV         (INV_MASK[i])
      ) u_ch (
         .clk        (clk),
         .rst        (rst),
         .raw_i      (raw_in[i]),
         .level_o    (level[i]),
         .rise_o     (rise[i]),
         .fall_o     (fall[i]),
         .rise_nxt_o (rise_nxt[i]),
         .long_o     (long_press[i])
      );
   end

   // Registered from the channels' next-state pulses so it lines up with rise.
   assign any_rise_d = |rise_nxt;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         any_rise_q <= 1'b0;
      end else begin
         any_rise_q <= any_rise_d;
      end
   end

   assign any_rise = any_rise_q;

endmodule

// File: tb/tb_debounce_multi.sv
// Directed bench for debounce_multi with CNT_MAX=4, SYNC_STAGES=2, LONG_CYCLES=20.
module tb_debounce_multi;

   localparam int unsigned N = 4;
`ifdef DEBOUNCE_LONG_PRESS_EN
   localparam bit LP_EN = 1'b1;
`else
   localparam bit LP_EN = 1'b0;
`endif

   logic         clk;
   logic         rst;
   logic [N-1:0] raw;
   logic [N-1:0] level, rise, fall, long_press;
   logic         any_rise;

   int n_chk  = 0;
   int n_fail = 0;
   int lp_seen = 0;

   debounce_multi #(
      .N_CH        (N),
      .CNT_MAX     (4),
      .SYNC_STAGES (2),
      .INV_MASK    (4'b1000),
      .LONG_CYCLES (20)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .raw_in     (raw),
      .level      (level),
      .rise       (rise),
      .fall       (fall),
      .any_rise   (any_rise),
      .long_press (long_press)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) if (long_press != '0) lp_seen++;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      rst = 1'b0;
      raw = 4'b1000;
      repeat (3) tick();
      chk("rst_level", level, 0);
      chk("rst_rise", rise, 0);
      chk("rst_fall", fall, 0);
      chk("rst_any", any_rise, 0);
      chk("rst_long", long_press, 0);
      rst = 1'b1;
      repeat (8) tick();
      chk("idle_level", level, 0);

      // clean press on channel 0
      raw[0] = 1'b1;
      repeat (5) tick();
      chk("press_early", level, 4'b0000);
      tick();
      chk("press_level", level, 4'b0001);
      chk("press_rise", rise, 4'b0001);
      chk("press_any", any_rise, 1);
      chk("press_fall", fall, 4'b0000);
      tick();
      chk("press_rise_end", rise, 4'b0000);
      chk("press_any_end", any_rise, 0);
      chk("press_hold", level, 4'b0001);

      // bounce on channel 1
      raw[1] = 1'b1; tick();
      raw[1] = 1'b0; tick();
      raw[1] = 1'b1; tick();
      raw[1] = 1'b0; tick();
      raw[1] = 1'b1;
      for (int k = 1; k <= 5; k++) begin
         tick();
         chk("bounce_wait", {level[1], rise[1]}, 2'b00);
      end
      tick();
      chk("bounce_level", level, 4'b0011);
      chk("bounce_rise", rise, 4'b0010);
      tick();
      chk("bounce_rise_end", rise, 4'b0000);

      // inverted channel 3
      raw[3] = 1'b0;
      repeat (5) tick();
      chk("inv_early", level[3], 0);
      tick();
      chk("inv_level", level, 4'b1011);
      chk("inv_rise", rise, 4'b1000);
      chk("inv_fall0", fall, 4'b0000);
      tick();
      chk("inv_rise_end", rise, 4'b0000);
      raw[3] = 1'b1;
      repeat (5) tick();
      chk("inv_fall_early", fall, 4'b0000);
      tick();
      chk("inv_fall", fall, 4'b1000);
      chk("inv_fall_rise", rise, 4'b0000);
      chk("inv_fall_level", level, 4'b0011);
      tick();
      chk("inv_fall_end", fall, 4'b0000);

      // simultaneous rise on channels 0 and 2
      raw[0] = 1'b0;
      repeat (6) tick();
      chk("sim_pre_fall", fall, 4'b0001);
      chk("sim_pre_level", level, 4'b0010);
      tick();
      raw = 4'b1111;
      repeat (5) tick();
      chk("sim_early", rise, 4'b0000);
      tick();
      chk("sim_rise", rise, 4'b0101);
      chk("sim_any", any_rise, 1);
      chk("sim_level", level, 4'b0111);
      chk("sim_fall", fall, 4'b0000);
      tick();
      chk("sim_rise_end", rise, 4'b0000);
      chk("sim_any_end", any_rise, 0);

      // long press held 30 cycles past rise
      raw[0] = 1'b0;
      repeat (6) tick();
      chk("lp_pre_fall", fall, 4'b0001);
      tick();
      raw[0] = 1'b1;
      repeat (6) tick();
      chk("lp_rise", rise, 4'b0001);
      for (int k = 1; k <= 30; k++) begin
         tick();
         chk("lp_hold", long_press[0], (LP_EN && k == 20) ? 1 : 0);
      end
      raw[0] = 1'b0;
      repeat (6) tick();
      chk("lp_release_fall", fall, 4'b0001);
      tick();

      // short press: level falls 15 cycles after rise
      raw[0] = 1'b1;
      repeat (6) tick();
      chk("sp_rise", rise, 4'b0001);
      for (int k = 1; k <= 9; k++) begin
         tick();
         chk("sp_hold", long_press[0], 0);
      end
      raw[0] = 1'b0;
      for (int k = 10; k <= 22; k++) begin
         tick();
         chk("sp_release", long_press[0], 0);
         if (k == 15) chk("sp_fall", fall, 4'b0001);
      end

      // reset two cycles into a count
      raw[0] = 1'b1;
      repeat (4) tick();
      rst = 1'b0;
      #1;
      chk("mid_rst_level", level, 0);
      chk("mid_rst_rise", rise, 0);
      chk("mid_rst_fall", fall, 0);
      chk("mid_rst_any", any_rise, 0);
      chk("mid_rst_long", long_press, 0);
      tick();
      rst = 1'b1;
      repeat (5) tick();
      chk("mid_rst_early", level, 0);
      tick();
      chk("mid_rst_relevel", level, 4'b0111);
      chk("mid_rst_rerise", rise, 4'b0111);
      chk("mid_rst_reany", any_rise, 1);
      tick();
      chk("mid_rst_rise_end", rise, 4'b0000);

`ifndef DEBOUNCE_LONG_PRESS_EN
      chk("long_never", lp_seen, 0);
`endif

      $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
      $finish;
   end

endmodule

// File: doc/debounce_multi.md
Name: debounce_multi

Overview:
- Parametrised N-channel successor to the single-button debouncer; serves Basys3 button banks and switches.
- Per channel: synchroniser, debounce counter, debounced level, one-cycle press and release pulses, per-channel polarity inversion, and an optional long-press pulse.
- Sits between board pins and the UART TX / control FSMs. The rise pulse replaces the old tx_start strobe.

Parameters:
- N_CH, 4, number of independent channels.
- CNT_MAX, 1_000_000, consecutive mismatch cycles needed to accept a new level (10 ms at 100 MHz); legal values are 1 or more.
- SYNC_STAGES, 2, synchroniser flop depth; legal values are 2 or more.
- INV_MASK, {N_CH{1'b0}}, bit i = 1 means channel i is an active-low input and is inverted after synchronisation.
- LONG_CYCLES, 100_000_000, held-press duration in cycles for the long pulse (1 s); used only with LONG_PRESS_EN.

Ports:
- clk  in  1  system clock, 100 MHz.
- rst  in  1  asynchronous reset, active-low (asserted at 0).
- raw_in  in  N_CH  noisy asynchronous inputs.
- level  out  N_CH  debounced, polarity-corrected level.
- rise  out  N_CH  one-cycle pulse on the first cycle level[i] reads 1.
- fall  out  N_CH  one-cycle pulse on the first cycle level[i] reads 0.
- any_rise  out  1  OR of rise, registered together with rise (same cycle).
- long_press  out  N_CH  one-cycle pulse per press held for LONG_CYCLES; constant 0 without LONG_PRESS_EN.

Behaviour:
- Reset (rst=0, asynchronous): all synchroniser flops, counters, level, rise, fall, any_rise and long_press clear to 0 immediately. The deassertion is taken synchronously by the fabric reset tree.
- Synchroniser: raw_in[i] passes through SYNC_STAGES flops, then is XORed with INV_MASK[i] to give s[i].
- Counter width is clog2(CNT_MAX+1), computed in the package, so there is no wrap for any legal CNT_MAX.
- Each cycle, per channel:
  - If s[i]==level[i]: cnt <= 0.
  - Otherwise, if cnt==CNT_MAX-1: level[i] <= s[i] and cnt <= 0.
  - Otherwise: cnt <= cnt+1.
- Any single-cycle return to agreement restarts the count (glitch rejection).
- Latency: level changes exactly SYNC_STAGES+CNT_MAX clock edges after the first edge that samples a stable new raw value.
- Pulses are registered:
  - rise[i] <= (level update to 1 this edge).
  - fall[i] <= (level update to 0 this edge).
  - Both are high in the same cycle level first shows its new value, for exactly one cycle.
  - rise[i] and fall[i] are never high together.
- Channels are fully independent; simultaneous events on several channels produce simultaneous pulses. any_rise is high if any rise bit is high.
- Inputs that are already high at reset deassertion are treated as new presses: rise fires after the normal latency.
- A reset mid-count discards partial counts. No pulse is generated by reset itself.

Optional Feature:
- Macro: DEBOUNCE_LONG_PRESS_EN.
- Defined:
  - Per-channel hold counter, width clog2(LONG_CYCLES+1), cleared while level[i]==0.
  - The counter increments while level[i]==1 and saturates at LONG_CYCLES.
  - long_press[i] pulses for one cycle when the counter transitions to LONG_CYCLES, so exactly once per press.
  - Releasing before LONG_CYCLES produces no pulse. A fall clears the counter on the same edge.
- Not defined: no hold counters are synthesised; long_press is tied to 0. The port list is unchanged.

Decomposition:
- Package debounce_pkg:
  - Width helper function (clog2-based) for the counter widths.
  - Default constants CLK_HZ=100_000_000, DEBOUNCE_MS=10 and LONG_MS=1000.
  - Derived cycle counts from those constants.
- Sub-module debounce_ch: one channel (synchroniser, counter, level, rise/fall, optional hold counter), instantiated N_CH times in a generate loop.
- The top level owns INV_MASK slicing and the any_rise OR.

Test Plan:
All scenarios use CNT_MAX=4, SYNC_STAGES=2, LONG_CYCLES=20, N_CH=4, INV_MASK=4'b1000.
- Clean press: raw_in[0] 0->1 held. level[0] rises 6 edges after the first sampling edge; rise[0]=1 for exactly one cycle; any_rise coincides with it; fall stays 0.
- Bounce: raw_in[1] toggles 1,0,1,0 on consecutive cycles, then holds 1. Level stays 0 during the bounce, rises 6 edges after the final 1 is sampled, and exactly one rise pulse occurs.
- Inverted channel: raw_in[3]=1 at reset release, so level[3] stays 0. Drive raw_in[3]=0, then level[3]=1 with rise[3] after 6 edges. Return raw_in[3] to 1, then fall[3] pulses once.
- Simultaneous events: raw_in[0] and raw_in[2] rise on the same cycle. rise=4'b0101 for one cycle and any_rise=1 for one cycle.
- Mid-count reset: assert rst=0 two cycles into a count. All outputs are 0 immediately; after release, a fresh full 6-edge latency is required.
- Long press (macro defined): hold channel 0 for 30 cycles after level rises. long_press[0] pulses once, 20 cycles after rise[0]. A release at 15 cycles gives no pulse. With the macro undefined, long_press stays 0 throughout.
